m_key_debounce: RTL
===================

M_KEY_DEBOUNCE -- requirements
Module: m_key_debounce

Interface
REQ-001 The block SHALL have parameter STABLE, default 4, giving the number of consecutive synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the debounce counter width; STABLE SHALL be at most 2^CNT_W-1.
REQ-003 CK  input  1  single clock; all state changes on its rising edge.
REQ-004 R  input  1  reset, synchronous, active-high.
REQ-005 KEY_IN  input  1  raw, bouncing key or switch level, asynchronous to CK.
REQ-006 KEY_LVL  output  1  debounced key level.
REQ-007 KEY_RISE  output  1  one-cycle pulse on an accepted 0->1 change; drives the flip-flop stage clock-enable or J input downstream.
REQ-008 KEY_FALL  output  1  one-cycle pulse on an accepted 1->0 change.
REQ-009 TGL  output  1  toggles on every accepted press, with JK toggle semantics.
REQ-010 PRESS_CNT  output  8  count of accepted presses.

Function
REQ-011 KEY_IN SHALL pass through a two-stage D synchronizer (s1, s2) before any other logic uses it.
REQ-012 The FSM SHALL have exactly four states: IDLE_LO, WAIT_HI, IDLE_HI and WAIT_LO.
REQ-013 IDLE_LO: if s2=1, go to WAIT_HI and set cnt=1; otherwise stay.
REQ-014 WAIT_HI, s2=1, cnt<STABLE-1: cnt increments and the state stays WAIT_HI.
REQ-015 WAIT_HI, s2=1, cnt=STABLE-1: go to IDLE_HI and clear cnt; on the same edge KEY_LVL<=1, KEY_RISE<=1, TGL<=~TGL and PRESS_CNT<=PRESS_CNT+1.
REQ-016 WAIT_HI, s2=0: return to IDLE_LO, clear cnt, and change no output (bounce rejected).
REQ-017 IDLE_HI, WAIT_LO: these states SHALL mirror REQ-013..016 with inverted s2.
REQ-018 On acceptance in WAIT_LO: KEY_LVL<=0 and KEY_FALL<=1; TGL and PRESS_CNT are unchanged.
REQ-019 KEY_RISE and KEY_FALL SHALL be high for exactly one cycle and SHALL never be high together.
REQ-020 Latency: a clean step is accepted on the (STABLE+2)th rising CK edge, counting the first edge that samples the new KEY_IN value. This is 2 synchronizer edges plus STABLE FSM samples.
REQ-021 Any glitch on s2 shorter than STABLE samples SHALL produce no output change.
REQ-022 PRESS_CNT SHALL wrap from 255 to 0 without saturating and without any flag.
REQ-023 cnt SHALL never exceed STABLE-1.
REQ-024 In IDLE_LO and IDLE_HI, cnt SHALL be 0.
REQ-025 All outputs SHALL be driven directly from registers, with no combinational path from KEY_IN.

Reset
REQ-026 When R=1 at a rising CK edge: s1=0, s2=0, state=IDLE_LO, cnt=0, and KEY_LVL, KEY_RISE, KEY_FALL, TGL and PRESS_CNT all become 0.
REQ-027 R SHALL take priority over every other event on the same edge, including an acceptance edge; that press is discarded.
REQ-028 Reset mid-WAIT_HI or mid-WAIT_LO SHALL abort the wait with no pulse.
REQ-029 If KEY_IN is held at 1 across a reset release, the block SHALL treat it as a new press, accepted per REQ-020 counting from the first edge with R=0.

Verification
REQ-030 With STABLE=4, hold R=1 for 2 edges with KEY_IN=0 -> all outputs read 0 and the state is IDLE_LO.
REQ-031 Step KEY_IN 0->1 and hold -> on the 6th edge KEY_LVL=1, KEY_RISE=1 for one cycle, TGL=1 and PRESS_CNT=1.
REQ-032 KEY_IN high for 3 edges then low, repeated 5 times -> KEY_LVL stays 0, no pulses, PRESS_CNT stays 0.
REQ-033 From the accepted-high state, step KEY_IN 1->0 and hold -> on the 6th edge KEY_LVL=0 and KEY_FALL=1 for one cycle; TGL=1 and PRESS_CNT=1 are unchanged.
REQ-034 Apply 256 clean press/release pairs -> PRESS_CNT=0 after the 256th press and TGL=0; after a 257th press, PRESS_CNT=1.
REQ-035 Assert R=1 on the 4th edge of a press, then release R with KEY_IN still 1 -> no pulse during the aborted press; KEY_RISE on the 6th edge after R is released; PRESS_CNT=1.

Source files
------------

// File: rtl/m_key_debounce.sv
// Key/switch debouncer: 2-flop synchronizer, 4-state stability FSM,
// registered level, edge pulses, JK-style toggle and press counter.
module m_key_debounce #(
  parameter int unsigned STABLE = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic       CK,
  input  logic       R,
  input  logic       KEY_IN,
  output logic       KEY_LVL,
  output logic       KEY_RISE,
  output logic       KEY_FALL,
  output logic       TGL,
  output logic [7:0] PRESS_CNT
);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             tgl_q, tgl_d;
  logic [7:0]       pcnt_q, pcnt_d;

  always_ff @(posedge CK) begin
    if (R) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      tgl_q   <= 1'b0;
      pcnt_q  <= 8'd0;
    end else begin
      s1_q    <= KEY_IN;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      tgl_q   <= tgl_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // cnt defaults to 0 so idle states and bounce rejects clear it
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    lvl_d   = lvl_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    tgl_d   = tgl_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      IDLE_LO: begin
        if (s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = ONE;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = IDLE_LO;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_HI;
          lvl_d   = 1'b1;
          rise_d  = 1'b1;
          tgl_d   = ~tgl_q;
          pcnt_d  = pcnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      IDLE_HI: begin
        if (!s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = ONE;
        end
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = IDLE_HI;
        end else if (cnt_q == LAST) begin
          state_d = IDLE_LO;
          lvl_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE_LO;
    endcase
  end

  assign KEY_LVL   = lvl_q;
  assign KEY_RISE  = rise_q;
  assign KEY_FALL  = fall_q;
  assign TGL       = tgl_q;
  assign PRESS_CNT = pcnt_q;

endmodule
